// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode constants, CSR op encoding and decoded bundle type
package decode_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        CSR_RW   = 2'd0,
        CSR_RS   = 2'd1,
        CSR_RC   = 2'd2,
        CSR_NONE = 2'd3
    } csr_op_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [3:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_en;
        logic        rs1_en;
        logic        rs2_en;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        auipc;
        logic [31:0] imm;
        csr_op_e     csr_op;
        logic        csr_imm_en;
        logic        csr_read_en;
        logic        csr_wr_en;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch-side and execute-side valid/ready bundle of the decode queue
interface decode_queue_if #(
    parameter int PC_W = 32
);
    import decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    dec_t            out_dec;
    logic [PC_W-1:0] out_pc;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_dec, out_pc
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_dec, out_pc
    );

endinterface

// File: rtl/rv32_decoder.sv
// rtl/rv32_decoder.sv - combinational RV32I decoder with immediate generation and illegal check
// Zicsr decode is built only when DECODE_ZICSR_EN is defined.
module rv32_decoder
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        legal;
    dec_t        raw;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        raw        = '0;
        raw.opcode = opc;
        raw.funct3 = {inst[30], f3};
        raw.funct7 = f7;
        raw.rd     = inst[11:7];
        raw.rs1    = inst[19:15];
        raw.rs2    = inst[24:20];
        raw.csr_op = CSR_NONE;
        legal      = (inst[1:0] == 2'b11);

        case (opc)
            LUI: begin
                raw.rd_en = 1'b1;
                raw.lui   = 1'b1;
                raw.imm   = imm_u;
            end
            AUIPC: begin
                raw.rd_en = 1'b1;
                raw.auipc = 1'b1;
                raw.imm   = imm_u;
            end
            JAL: begin
                raw.rd_en = 1'b1;
                raw.jal   = 1'b1;
                raw.imm   = imm_j;
            end
            JALR: begin
                raw.rd_en  = 1'b1;
                raw.rs1_en = 1'b1;
                raw.jalr   = 1'b1;
                raw.imm    = imm_i;
                if (f3 != 3'd0) legal = 1'b0;
            end
            BRANCH: begin
                raw.rs1_en = 1'b1;
                raw.rs2_en = 1'b1;
                raw.branch = 1'b1;
                raw.imm    = imm_b;
                if (f3 == 3'd2 || f3 == 3'd3) legal = 1'b0;
            end
            LOAD: begin
                raw.rd_en    = 1'b1;
                raw.rs1_en   = 1'b1;
                raw.mem_read = 1'b1;
                raw.imm      = imm_i;
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) legal = 1'b0;
            end
            STORE: begin
                raw.rs1_en    = 1'b1;
                raw.rs2_en    = 1'b1;
                raw.mem_write = 1'b1;
                raw.imm       = imm_s;
                if (f3 > 3'd2) legal = 1'b0;
            end
            OP_IMM: begin
                raw.rd_en  = 1'b1;
                raw.rs1_en = 1'b1;
                raw.imm    = imm_i;
                // only the shift encodings constrain the upper immediate bits
                if (f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
                if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) legal = 1'b0;
            end
            OP: begin
                raw.rd_en  = 1'b1;
                raw.rs1_en = 1'b1;
                raw.rs2_en = 1'b1;
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) legal = 1'b0;
            end
            SYSTEM: begin
                raw.imm = imm_i;
`ifdef DECODE_ZICSR_EN
                if (f3 == 3'd4) begin
                    legal = 1'b0;
                end else if (f3 != 3'd0) begin
                    raw.csr_imm_en = f3[2];
                    if (f3[1:0] == 2'd1) begin
                        raw.csr_op      = CSR_RW;
                        raw.csr_read_en = (raw.rd != 5'd0);
                        raw.csr_wr_en   = 1'b1;
                        raw.rs1_en      = !f3[2];
                    end else begin
                        raw.csr_op      = (f3[1:0] == 2'd2) ? CSR_RS : CSR_RC;
                        raw.csr_read_en = 1'b1;
                        raw.csr_wr_en   = (raw.rs1 != 5'd0);
                        raw.rs1_en      = !f3[2] && (raw.rs1 != 5'd0);
                    end
                    raw.rd_en = raw.csr_read_en;
                end
`else
                if (f3 != 3'd0) legal = 1'b0;
`endif
            end
            default: legal = 1'b0;
        endcase

        dec = raw;
        if (!legal) begin
            dec.rd_en       = 1'b0;
            dec.rs1_en      = 1'b0;
            dec.rs2_en      = 1'b0;
            dec.mem_read    = 1'b0;
            dec.mem_write   = 1'b0;
            dec.branch      = 1'b0;
            dec.jal         = 1'b0;
            dec.jalr        = 1'b0;
            dec.lui         = 1'b0;
            dec.auipc       = 1'b0;
            dec.csr_op      = CSR_NONE;
            dec.csr_imm_en  = 1'b0;
            dec.csr_read_en = 1'b0;
            dec.csr_wr_en   = 1'b0;
            dec.illegal     = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - registered decode stage: decoder feeding a QDEPTH-entry queue with load-use hold
// Optional Zicsr decode selected by DECODE_ZICSR_EN (inside rv32_decoder).
module decode_queue
    import decode_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int PC_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           ex_ld_valid,
    input  logic [4:0]     ex_ld_rd,
    decode_queue_if.slave  q_if
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    dec_t            in_dec;
    dec_t            dec_mem_q [QDEPTH];
    dec_t            dec_mem_d [QDEPTH];
    logic [PC_W-1:0] pc_mem_q  [QDEPTH];
    logic [PC_W-1:0] pc_mem_d  [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    dec_t head;
    logic full;
    logic empty;
    logic hazard;
    logic out_valid;
    logic push;
    logic pop;

    rv32_decoder u_dec (
        .inst (q_if.in_inst),
        .dec  (in_dec)
    );

    always_comb begin
        full   = (count_q == FULL_CNT);
        empty  = (count_q == '0);
        head   = dec_mem_q[rd_ptr_q];
        hazard = ex_ld_valid &&
                 ((head.rs1_en && head.rs1 != 5'd0 && head.rs1 == ex_ld_rd) ||
                  (head.rs2_en && head.rs2 != 5'd0 && head.rs2 == ex_ld_rd));
        out_valid = !empty && !hazard;
        // full blocks input even when a pop happens this cycle
        push = q_if.in_valid && !full && !flush;
        pop  = out_valid && q_if.out_ready && !flush;
    end

    assign q_if.in_ready  = !full;
    assign q_if.out_valid = out_valid;
    assign q_if.out_dec   = head;
    assign q_if.out_pc    = pc_mem_q[rd_ptr_q];

    always_comb begin
        dec_mem_d = dec_mem_q;
        pc_mem_d  = pc_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                dec_mem_d[wr_ptr_q] = in_dec;
                pc_mem_d[wr_ptr_q]  = q_if.in_pc;
                wr_ptr_d            = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage carries no reset; entries are only observable behind a valid count
    always_ff @(posedge clk) begin
        dec_mem_q <= dec_mem_d;
        pc_mem_q  <= pc_mem_d;
    end

endmodule
